pipelined_barrel_shifter: RTL and testbench

- Parametrised, pipelined barrel shifter for N-bit data with four shift modes and a per-beat shift amount.
- Uses a log2(N)-stage registered datapath with valid/ready handshakes on input and output.
- Serves as the sequential, stall-aware successor to the combinational parametrised right shifter.
- Sits between a producer and a consumer stream inside the datapath.

---
 rtl/pipelined_barrel_shifter_pkg.sv | 23 ++
 rtl/pipelined_barrel_shifter_stage.sv | 50 +++++
 rtl/pipelined_barrel_shifter.sv | 106 ++++++++++
 tb/tb_pipelined_barrel_shifter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/pipelined_barrel_shifter_pkg.sv
// Shared types and helpers for the pipelined barrel shifter.
//   shift_mode_e : shift mode encoding carried with every beat
//   stage_count  : number of single-bit-of-amount stages for an N-bit word
package shifter_pkg;

  typedef enum logic [1:0] {
    SHIFT_SLL = 2'b00,  // logical left, zero fill
    SHIFT_SRL = 2'b01,  // logical right, zero fill
    SHIFT_SRA = 2'b10,  // arithmetic right, fill with original MSB
    SHIFT_ROR = 2'b11   // rotate right
  } shift_mode_e;

  // ceil(log2(n)): one stage per bit of the shift amount
  function automatic int stage_count(input int n);
    int s;
    s = 0;
    for (int p = 1; p < n; p = p * 2) begin
      s = s + 1;
    end
    return s;
  endfunction

endpackage

// File: rtl/pipelined_barrel_shifter_stage.sv
// shift_stage: combinational shift of one pipeline stage by 2^K bit positions.
//   din  : data entering the stage
//   en   : amount bit K; when low the data passes unchanged
//   mode : shift mode of the beat
//   sign : original MSB of the beat, used as SRA fill
//   dout : shifted data
module shift_stage
  import shifter_pkg::*;
#(
  parameter int N = 8,
  parameter int K = 0
) (
  input  logic [N-1:0] din,
  input  logic         en,
  input  shift_mode_e  mode,
  input  logic         sign,
  output logic [N-1:0] dout
);

  localparam int S = 1 << K;

  logic [N-1:0] shifted_s;
  logic [N-1:0] high_mask_s;

  // Top S bits set; these are the positions a right shift vacates
  assign high_mask_s = ~({N{1'b1}} >> S);

  // Mode-dependent shift by the fixed distance of this stage
  always_comb begin
    shifted_s = din;
    case (mode)
      SHIFT_SLL: shifted_s = din << S;
      SHIFT_SRL: shifted_s = din >> S;
      // fill uses the beat's original MSB, not this stage's din MSB
      SHIFT_SRA: shifted_s = (din >> S) | ({N{sign}} & high_mask_s);
      SHIFT_ROR: shifted_s = (din >> S) | (din << (N - S));
      default:   shifted_s = din;
    endcase
  end

  // Apply the shift only when this stage's amount bit is set
  always_comb begin
    if (en) begin
      dout = shifted_s;
    end else begin
      dout = din;
    end
  end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// pipelined_barrel_shifter: log2(N)-stage registered barrel shifter with
// valid/ready handshakes. Stage k applies the 2^k shift to the beat and
// registers it; the last stage register drives the output directly.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : input handshake
//   in_data, in_amt, in_mode : operand, shift amount, shift mode
//   out_valid / out_ready    : output handshake
//   out_data            : shifted result
module pipelined_barrel_shifter
  import shifter_pkg::*;
#(
  parameter  int N      = 8,
  localparam int STAGES = stage_count(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         in_data,
  input  logic [$clog2(N)-1:0] in_amt,
  input  logic [1:0]           in_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0]         out_data
);

  // Amount, mode and sign are only needed by downstream stages, so the last
  // stage does not keep them.
  localparam int SIDE = (STAGES > 1) ? STAGES - 1 : 1;

  logic [STAGES-1:0] valid_r;
  logic [N-1:0]      data_r   [STAGES];
  logic [STAGES-1:0] amt_r    [SIDE];
  shift_mode_e       mode_r   [SIDE];
  logic              sign_r   [SIDE];

  logic              adv_s;
  logic [STAGES-1:0] valid_in_s;
  logic [N-1:0]      stage_in_s   [STAGES];
  logic [N-1:0]      stage_out_s  [STAGES];
  logic [STAGES-1:0] stage_amt_s  [STAGES];
  shift_mode_e       stage_mode_s [STAGES];
  logic              stage_sign_s [STAGES];

  // The whole pipe moves together; bubbles advance like beats.
  assign adv_s    = out_ready | ~out_valid;
  assign in_ready = adv_s;

  generate
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
      if (k == 0) begin : g_head
        assign valid_in_s[k]   = in_valid;
        assign stage_in_s[k]   = in_data;
        assign stage_amt_s[k]  = in_amt;
        assign stage_mode_s[k] = shift_mode_e'(in_mode);
        assign stage_sign_s[k] = in_data[N-1];
      end else begin : g_body
        assign valid_in_s[k]   = valid_r[k-1];
        assign stage_in_s[k]   = data_r[k-1];
        assign stage_amt_s[k]  = amt_r[k-1];
        assign stage_mode_s[k] = mode_r[k-1];
        assign stage_sign_s[k] = sign_r[k-1];
      end

      shift_stage #(
        .N (N),
        .K (k)
      ) u_shift_stage (
        .din  (stage_in_s[k]),
        .en   (stage_amt_s[k][k]),
        .mode (stage_mode_s[k]),
        .sign (stage_sign_s[k]),
        .dout (stage_out_s[k])
      );
    end
  endgenerate

  // Pipeline registers: cleared on reset, loaded on advance, held otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= {STAGES{1'b0}};
      for (int k = 0; k < STAGES; k++) begin
        data_r[k] <= {N{1'b0}};
      end
      for (int k = 0; k < SIDE; k++) begin
        amt_r[k]  <= {STAGES{1'b0}};
        mode_r[k] <= SHIFT_SLL;
        sign_r[k] <= 1'b0;
      end
    end else if (adv_s) begin
      valid_r <= valid_in_s;
      for (int k = 0; k < STAGES; k++) begin
        data_r[k] <= stage_out_s[k];
      end
      for (int k = 0; k < STAGES - 1; k++) begin
        amt_r[k]  <= stage_amt_s[k];
        mode_r[k] <= stage_mode_s[k];
        sign_r[k] <= stage_sign_s[k];
      end
    end
  end

  assign out_valid = valid_r[STAGES-1];
  assign out_data  = data_r[STAGES-1];

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Self-checking bench for pipelined_barrel_shifter (N = 8, three stages).
// Directed vectors with hand-computed results; all checks via check_eq.
module tb_pipelined_barrel_shifter;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] in_amt;
  logic [1:0] in_mode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;

  int n_vec;
  int n_err;

  logic       capture_en;
  logic [7:0] got_q [$];

  pipelined_barrel_shifter #(.N(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Record every retired beat between edges while capture is enabled
  always @(negedge clk) begin
    if (capture_en && out_valid && out_ready) begin
      got_q.push_back(out_data);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One isolated beat: accepted at edge t, visible after edge t+2, not before
  task automatic run_one(input string tag, input logic [1:0] mode,
                         input logic [7:0] data, input logic [2:0] amt,
                         input logic [7:0] exp);
    in_valid = 1'b1;
    in_mode  = mode;
    in_data  = data;
    in_amt   = amt;
    check_eq({tag, "_rdy"}, in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    in_data  = 8'h00;
    in_amt   = 3'd0;
    step();
    check_eq({tag, "_early"}, out_valid, 1'b0);
    step();
    check_eq({tag, "_vld"}, out_valid, 1'b1);
    check_eq({tag, "_data"}, out_data, exp);
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    capture_en = 1'b0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    in_amt     = 3'd0;
    in_mode    = 2'b00;
    out_ready  = 1'b1;

    // Reset state
    #3;
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_out_data", out_data, 8'h00);
    check_eq("rst_in_ready", in_ready, 1'b1);
    #9 rst_n = 1'b1;
    step();

    // Single beats through every mode
    run_one("sll_81_1", 2'b00, 8'h81, 3'd1, 8'h02);
    run_one("sra_90_3", 2'b10, 8'h90, 3'd3, 8'hF2);
    run_one("srl_90_3", 2'b01, 8'h90, 3'd3, 8'h12);
    run_one("srl_ff_7", 2'b01, 8'hFF, 3'd7, 8'h01);
    run_one("sll_5c_0", 2'b00, 8'h5C, 3'd0, 8'h5C);
    run_one("srl_5c_0", 2'b01, 8'h5C, 3'd0, 8'h5C);
    run_one("sra_5c_0", 2'b10, 8'h5C, 3'd0, 8'h5C);
    run_one("ror_5c_0", 2'b11, 8'h5C, 3'd0, 8'h5C);
    run_one("ror_01_1", 2'b11, 8'h01, 3'd1, 8'h80);
    run_one("ror_a5_4", 2'b11, 8'hA5, 3'd4, 8'h5A);
    run_one("sll_ff_7", 2'b00, 8'hFF, 3'd7, 8'h80);
    run_one("sra_7f_6", 2'b10, 8'h7F, 3'd6, 8'h01);
    run_one("ror_81_7", 2'b11, 8'h81, 3'd7, 8'h03);
    step();

    // Back-to-back beats with a two-cycle output stall
    got_q.delete();
    capture_en = 1'b1;
    in_mode    = 2'b00;
    in_data    = 8'h01;
    in_valid   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_amt = 3'(i);
      step();
    end
    in_amt = 3'd3;
    check_eq("b2b_first_vld", out_valid, 1'b1);
    check_eq("b2b_first_data", out_data, 8'h01);
    out_ready = 1'b0;
    #1;
    check_eq("b2b_stall_rdy0", in_ready, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step();
      check_eq("b2b_hold_vld", out_valid, 1'b1);
      check_eq("b2b_hold_data", out_data, 8'h01);
      check_eq("b2b_hold_rdy", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    #1;
    check_eq("b2b_resume_rdy", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
    end
    capture_en = 1'b0;
    check_eq("b2b_count", got_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < got_q.size()) begin
        check_eq("b2b_order", got_q[i], 8'h01 << i);
      end
    end

    // Alternating valid pattern: bubbles preserved three cycles later
    for (int i = 0; i < 9; i++) begin
      in_valid = (i < 6) && (i % 2 == 0);
      in_mode  = 2'b00;
      in_amt   = 3'd0;
      in_data  = 8'(i + 1);
      step();
      if (i >= 2) begin
        check_eq("alt_vld", out_valid, (i - 2 < 6) && ((i - 2) % 2 == 0));
        if ((i - 2 < 6) && ((i - 2) % 2 == 0)) begin
          check_eq("alt_data", out_data, 8'(i - 1));
        end
      end
    end
    in_valid = 1'b0;
    step();

    // Reset while beats are in flight
    in_valid = 1'b1;
    in_mode  = 2'b00;
    in_amt   = 3'd0;
    in_data  = 8'h33;
    for (int i = 0; i < 3; i++) begin
      step();
    end
    in_valid = 1'b0;
    check_eq("mid_pre_vld", out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_vld", out_valid, 1'b0);
    check_eq("mid_rst_data", out_data, 8'h00);
    check_eq("mid_rst_rdy", in_ready, 1'b1);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("mid_post_vld", out_valid, 1'b0);
    end
    run_one("post_rst", 2'b01, 8'hC0, 3'd6, 8'h03);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
